// File: rtl/seq_sort_pkg.sv
// Shared definitions for the sequence sorter: the feeder FSM state type, the
// frame-counter width helper, and the default data width / frame size so the
// feeder and the comparator chain are built from the same numbers.
package seq_sort_pkg;

  // Default word width and words per frame (N >= 2).
  localparam int unsigned SortDw = 8;
  localparam int unsigned SortN  = 4;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StPad     = 3'd2,
    StSettle  = 3'd3,
    StWaitAck = 3'd4,
    StClear   = 3'd5
  } feeder_state_e;

endpackage

// File: rtl/seq_sort_feeder.sv
// seq_sort_feeder: framing stage in front of the sorter's comparator chain.
// Accepts N words per frame over valid/ready, forwards each accepted word to
// the first comparator cell as a registered one-cycle load strobe, flags when
// the sorted frame is resident, and on rd_ack pulses cell_clear once so the
// chain drops its stored maxima before the next frame.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_data      input word (DW bits)
//   in_valid     in_data valid
//   in_last      last real word of a short frame (pad build only)
//   in_ready     feeder can accept; accept = in_valid & in_ready
//   cell_inp     registered word to the chain input
//   cell_load    one-cycle strobe, cell_inp valid
//   cell_clear   one-cycle strobe, chain clears stored max
//   frame_done   level, chain holds the sorted frame
//   frame_len    real words in the current frame (CW bits)
//   rd_ack       downstream has read the sorted frame
//
// Build option: define SORT_FEEDER_PAD_EN to let in_last end a frame early;
// the remaining slots are then filled with zero pad words.
module seq_sort_feeder
  import seq_sort_pkg::*;
#(
  parameter int unsigned DW = SortDw,
  parameter int unsigned N  = SortN,
  localparam int unsigned CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] cell_inp,
  output logic          cell_load,
  output logic          cell_clear,
  output logic          frame_done,
  output logic [CW-1:0] frame_len,
  input  logic          rd_ack
);

  localparam logic [CW-1:0] CntLast = CW'(N - 1);
  localparam logic [CW-1:0] CntFull = CW'(N);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] flen_q, flen_d;
  logic [DW-1:0] inp_q, inp_d;
  logic          load_q, load_d;
  logic          ready_q, ready_d;
  logic          accept;

`ifndef SORT_FEEDER_PAD_EN
  // Without padding every frame is exactly N words; in_last has no meaning.
  logic unused_last;
  assign unused_last = in_last;
`endif

  assign accept = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flen_d  = flen_q;
    inp_d   = inp_q;
    load_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StLoad;
      end
      StLoad: begin
        if (accept) begin
          if (cnt_q == CntLast) begin
            state_d = StSettle;
          end
`ifdef SORT_FEEDER_PAD_EN
          else if (in_last) begin
            state_d = StPad;
          end
`endif
        end
      end
      StPad: begin
`ifdef SORT_FEEDER_PAD_EN
        // Zero pads are contiguous with the last real load; frame_len stays.
        inp_d  = '0;
        load_d = 1'b1;
        if (cnt_q < CntFull) cnt_d = cnt_q + CW'(1);
        if (cnt_q == CntLast) state_d = StSettle;
`else
        state_d = StIdle;
`endif
      end
      StSettle: begin
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (rd_ack) begin
          state_d = StClear;
          cnt_d   = '0;
          flen_d  = '0;
        end
      end
      StClear: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Accepts only occur in IDLE/LOAD; forward the word with one cycle latency.
    if (accept) begin
      inp_d  = in_data;
      load_d = 1'b1;
      if (cnt_q < CntFull) begin
        cnt_d  = cnt_q + CW'(1);
        flen_d = flen_q + CW'(1);
      end
    end
  end

  // Registered from the next state so in_ready is low while reset is held and
  // rises on the first edge after release.
  assign ready_d = (state_d == StIdle) || (state_d == StLoad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      flen_q  <= '0;
      inp_q   <= '0;
      load_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flen_q  <= flen_d;
      inp_q   <= inp_d;
      load_q  <= load_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready   = ready_q;
  assign cell_inp   = inp_q;
  assign cell_load  = load_q;
  assign cell_clear = (state_q == StClear);
  assign frame_done = (state_q == StWaitAck);
  assign frame_len  = flen_q;

endmodule

// File: tb/tb_seq_sort_feeder.sv
// Self-checking bench for seq_sort_feeder (DW=8, N=4). Per-cycle vectors give
// the inputs for a cycle and the outputs expected in that cycle; accepted
// words are pushed to a scoreboard and matched against cell_load strobes,
// including the cycle on which each load must appear.
module tb_seq_sort_feeder;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] cell_inp;
  logic          cell_load;
  logic          cell_clear;
  logic          frame_done;
  logic [CW-1:0] frame_len;
  logic          rd_ack;

  seq_sort_feeder #(
    .DW(DW),
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .cell_inp  (cell_inp),
    .cell_load (cell_load),
    .cell_clear(cell_clear),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .rd_ack    (rd_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          last;
    logic          ack;
    logic          pad;   // a zero pad load is expected next cycle
    logic          rdy;
    logic          done;
    logic          clr;
    logic [CW-1:0] len;
  } row_t;

  typedef struct {
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  row_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic row_t mk(logic v, logic [DW-1:0] d, logic last, logic ack, logic pad,
                              logic rdy, logic done, logic clr, logic [CW-1:0] len);
    row_t r;
    r.v = v; r.d = d; r.last = last; r.ack = ack; r.pad = pad;
    r.rdy = rdy; r.done = done; r.clr = clr; r.len = len;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Match a load strobe in the current cycle against the scoreboard head.
  task automatic sb_sample();
    exp_t e;
    check("load_clear_excl", 32'(cell_load & cell_clear), 32'd0);
    if (cell_load) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_load @cyc %0d: got cell_inp %0h want no load", cyc, cell_inp);
      end else begin
        e = exp_q.pop_front();
        check("cell_inp", 32'(cell_inp), 32'(e.d));
        check("load_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_load @cyc %0d: got no load want cell_inp %0h", cyc, e.d);
    end
  endtask

  task automatic apply_row(input row_t r);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = r.v;
    in_data  = r.d;
    in_last  = r.last;
    rd_ack   = r.ack;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(r.rdy));
    check("frame_done", 32'(frame_done), 32'(r.done));
    check("cell_clear", 32'(cell_clear), 32'(r.clr));
    check("frame_len", 32'(frame_len), 32'(r.len));
    sb_sample();
    if (r.v && r.rdy) begin
      e.d = r.d; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    if (r.pad) begin
      e.d = '0; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_cell_inp"}, 32'(cell_inp), 32'd0);
    check({tag, "_cell_load"}, 32'(cell_load), 32'd0);
    check({tag, "_cell_clear"}, 32'(cell_clear), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        v  data   last ack pad  rdy done clr len
    // Full frame 5,9,2,7 back to back; rd_ack in LOAD is ignored.
    tbl.push_back(mk(1, 8'h05, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h09, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h02, 0, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(1, 8'h07, 0, 0, 0, 1, 0, 0, 3));
    // Source keeps valid high through SETTLE/WAIT_ACK/CLEAR: nothing accepted.
    tbl.push_back(mk(1, 8'haa, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 8'haa, 0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(1, 8'haa, 0, 1, 0, 0, 1, 0, 4));
    tbl.push_back(mk(1, 8'haa, 0, 0, 0, 0, 0, 1, 0));
    // Back in IDLE: held word accepted, then gapped pattern 1,0,1,1,0,1.
    tbl.push_back(mk(1, 8'haa, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 8'h33, 0, 0, 0, 1, 0, 0, 3));
    // rd_ack during SETTLE is ignored; only the one in WAIT_ACK counts.
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; rd_ack = 1'b0;

    // Reset held, then release: in_ready rises one edge after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_release", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_idle_async");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i]);

    // Short frame 3,8 with in_last on 8.
`ifdef SORT_FEEDER_PAD_EN
    apply_row(mk(1, 8'h03, 0, 0, 0, 1, 0, 0, 0));
    apply_row(mk(1, 8'h08, 1, 0, 0, 1, 0, 0, 1));
    apply_row(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 2));
    apply_row(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 2));
    apply_row(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 2));
    apply_row(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 2));
    apply_row(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    apply_row(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
`else
    apply_row(mk(1, 8'h03, 0, 0, 0, 1, 0, 0, 0));
    apply_row(mk(1, 8'h08, 1, 0, 0, 1, 0, 0, 1));
    apply_row(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 2));
    apply_row(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 2));
    apply_row(mk(1, 8'h0c, 0, 0, 0, 1, 0, 0, 2));
    apply_row(mk(1, 8'h0d, 0, 0, 0, 1, 0, 0, 3));
    apply_row(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 4));
    apply_row(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 4));
    apply_row(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    apply_row(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
`endif

    // Async reset after two accepts kills the pending load and the partial frame.
    apply_row(mk(1, 8'h01, 0, 0, 0, 1, 0, 0, 0));
    apply_row(mk(1, 8'h02, 0, 0, 0, 1, 0, 0, 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_midframe");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Next frame starts from cnt=0 and needs all four words.
    apply_row(mk(1, 8'h40, 0, 0, 0, 1, 0, 0, 0));
    apply_row(mk(1, 8'h41, 0, 0, 0, 1, 0, 0, 1));
    apply_row(mk(1, 8'h42, 0, 0, 0, 1, 0, 0, 2));
    apply_row(mk(1, 8'h43, 0, 0, 0, 1, 0, 0, 3));
    apply_row(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 4));
    apply_row(mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 4));
    apply_row(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 0));
    apply_row(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
